// File: rtl/writeback_unit.sv
// Writeback stage: buffers retired instructions in a small FIFO, selects and aligns the
// writeback value at push time, and drives the regfile write port plus a same-cycle bypass.
module writeback_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk2,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_IR,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_mem,
    input  logic [XLEN-1:0] in_pc4,
    input  logic            wb_stall,
    output logic            wr,
    output logic [XLEN-1:0] result,
    output logic [31:0]     write_IR,
    output logic            byp_valid,
    output logic [4:0]      byp_rd,
    output logic [XLEN-1:0] byp_data,
    output logic [31:0]     retired
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [XLEN-1:0] load_align(input logic [2:0]      f3,
                                                   input logic [1:0]      addr,
                                                   input logic [XLEN-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{addr, 3'b000} +: 8];
        h = addr[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_align = {{(XLEN-8){b[7]}}, b};
            3'b100:  load_align = {{(XLEN-8){1'b0}}, b};
            3'b001:  load_align = {{(XLEN-16){h[15]}}, h};
            3'b101:  load_align = {{(XLEN-16){1'b0}}, h};
            default: load_align = word;
        endcase
    endfunction

    // Returns {we, value}; non-writing opcodes and rd==x0 never assert we.
    function automatic logic [XLEN:0] wb_select(input logic [31:0]     ir,
                                                input logic [XLEN-1:0] alu,
                                                input logic [XLEN-1:0] mem,
                                                input logic [XLEN-1:0] pc4);
        logic            we;
        logic [XLEN-1:0] val;
        we  = 1'b1;
        val = '0;
        case (ir[6:0])
            7'b0110011, 7'b0010011,
            7'b0110111, 7'b0010111: val = alu;
            7'b1101111, 7'b1100111: val = pc4;
            7'b0000011:             val = load_align(ir[14:12], alu[1:0], mem);
            default:                we  = 1'b0;
        endcase
        if (ir[11:7] == 5'd0)
            we = 1'b0;
        wb_select = {we, val};
    endfunction

    logic [31:0]     fifo_ir_p1  [DEPTH];
    logic [XLEN-1:0] fifo_val_p1 [DEPTH];
    logic [DEPTH-1:0] fifo_we_p1;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [XLEN:0]   sel_p0;
    logic            push, pop;

    assign in_ready = (count < FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && !wb_stall;
    assign sel_p0   = wb_select(in_IR, in_alu, in_mem, in_pc4);

    // Stage p0 -> p1: selected value enters the FIFO
    always_ff @(posedge clk2) begin
        if (push) begin
            fifo_ir_p1[wr_ptr]  <= in_IR;
            fifo_val_p1[wr_ptr] <= sel_p0[XLEN-1:0];
            fifo_we_p1[wr_ptr]  <= sel_p0[XLEN];
        end
    end

    always_ff @(posedge clk2) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Stage p1 -> p2: FIFO head drives the regfile write port
    always_ff @(posedge clk2) begin
        if (!rst) begin
            wr       <= 1'b0;
            result   <= '0;
            write_IR <= NOP;
            retired  <= '0;
        end else if (pop) begin
            wr       <= fifo_we_p1[rd_ptr];
            result   <= fifo_val_p1[rd_ptr];
            write_IR <= fifo_ir_p1[rd_ptr];
            retired  <= retired + 32'd1;
        end else begin
            wr <= 1'b0;
        end
    end

    assign byp_valid = wr;
    assign byp_rd    = write_IR[11:7];
    assign byp_data  = result;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: reset, value select/alignment, stall, back-to-back, mid-run reset.
module tb_writeback_unit;
    logic        clk2 = 1'b0;
    logic        rst, in_valid, in_ready, wb_stall, wr, byp_valid;
    logic [31:0] in_IR, in_alu, in_mem, in_pc4, result, write_IR, byp_data, retired;
    logic [4:0]  byp_rd;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_ret = 32'd0;

    writeback_unit #(.XLEN(32), .DEPTH(2)) dut (
        .clk2(clk2), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_IR(in_IR),
        .in_alu(in_alu), .in_mem(in_mem), .in_pc4(in_pc4), .wb_stall(wb_stall), .wr(wr),
        .result(result), .write_IR(write_IR), .byp_valid(byp_valid), .byp_rd(byp_rd),
        .byp_data(byp_data), .retired(retired)
    );

    always #5 clk2 = ~clk2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk2);
        #1;
    endtask

    task automatic drive(input logic [31:0] ir, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] pc4);
        in_valid = 1'b1;
        in_IR    = ir;
        in_alu   = alu;
        in_mem   = mem;
        in_pc4   = pc4;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; wb_stall = 1'b0;
        in_IR = 32'h0; in_alu = 32'h0; in_mem = 32'h0; in_pc4 = 32'h0;
        repeat (2) step();
        rst = 1'b1;
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b expected 0", wr); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
        checks++; if (write_IR !== 32'h13) begin errors++; $display("FAIL reset_write_IR: got %h expected 00000013", write_IR); end
        checks++; if (retired !== 32'h0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_add();
        drive(32'h002082B3, 32'h1234, 32'h0, 32'h0);
        step();
        in_valid = 1'b0;
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL add_latency: wr got %b expected 0", wr); end
        step();
        exp_ret++;
        checks++; if (wr !== 1'b1 || byp_valid !== 1'b1) begin errors++; $display("FAIL add_wr: wr=%b byp_valid=%b expected 1", wr, byp_valid); end
        checks++; if (byp_rd !== 5'd5) begin errors++; $display("FAIL add_rd: got %0d expected 5", byp_rd); end
        checks++; if (result !== 32'h1234 || byp_data !== 32'h1234) begin errors++; $display("FAIL add_result: got %h/%h expected 00001234", result, byp_data); end
        checks++; if (retired !== exp_ret) begin errors++; $display("FAIL add_retired: got %0d expected %0d", retired, exp_ret); end
        step();
        checks++; if (wr !== 1'b0 || result !== 32'h1234) begin errors++; $display("FAIL add_hold: wr=%b result=%h expected 0/00001234", wr, result); end
    endtask

    task automatic test_loads();
        logic [31:0] irs  [6] = '{32'h00008303, 32'h0000C303, 32'h00009303, 32'h0000D303, 32'h0000A303, 32'h00008303};
        logic [31:0] alus [6] = '{32'h102, 32'h102, 32'h103, 32'h100, 32'h101, 32'h100};
        logic [31:0] exps [6] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01, 32'h00000001};
        for (int i = 0; i < 6; i++) begin
            drive(irs[i], alus[i], 32'h80FF7F01, 32'h0);
            step();
            in_valid = 1'b0;
            step();
            exp_ret++;
            checks++; if (wr !== 1'b1 || result !== exps[i]) begin errors++; $display("FAIL load_%0d: wr=%b result=%h expected 1/%h", i, wr, result, exps[i]); end
        end
        checks++; if (retired !== exp_ret) begin errors++; $display("FAIL load_retired: got %0d expected %0d", retired, exp_ret); end
    endtask

    task automatic test_stall();
        wb_stall = 1'b1;
        drive(32'h002083B3, 32'h11, 32'h0, 32'h0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready0: got %b expected 1", in_ready); end
        step();
        drive(32'h002083B3, 32'h22, 32'h0, 32'h0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready1: got %b expected 1", in_ready); end
        step();
        drive(32'h002083B3, 32'h33, 32'h0, 32'h0);
        checks++; if (in_ready !== 1'b0 || wr !== 1'b0) begin errors++; $display("FAIL stall_full: in_ready=%b wr=%b expected 0/0", in_ready, wr); end
        step();
        checks++; if (in_ready !== 1'b0 || wr !== 1'b0) begin errors++; $display("FAIL stall_hold: in_ready=%b wr=%b expected 0/0", in_ready, wr); end
        wb_stall = 1'b0;
        step();
        checks++; if (wr !== 1'b1 || result !== 32'h11) begin errors++; $display("FAIL stall_first: wr=%b result=%h expected 1/00000011", wr, result); end
        step();
        in_valid = 1'b0;
        checks++; if (wr !== 1'b1 || result !== 32'h22) begin errors++; $display("FAIL stall_second: wr=%b result=%h expected 1/00000022", wr, result); end
        step();
        checks++; if (wr !== 1'b1 || result !== 32'h33) begin errors++; $display("FAIL stall_third: wr=%b result=%h expected 1/00000033", wr, result); end
        step();
        exp_ret += 3;
        checks++; if (wr !== 1'b0 || retired !== exp_ret) begin errors++; $display("FAIL stall_drain: wr=%b retired=%0d expected 0/%0d", wr, retired, exp_ret); end
    endtask

    task automatic test_nowrite();
        drive(32'h0020A023, 32'h40, 32'h0, 32'h0);
        step();
        drive(32'h00000013, 32'h77, 32'h0, 32'h0);
        step();
        in_valid = 1'b0;
        checks++; if (wr !== 1'b0 || write_IR !== 32'h0020A023 || result !== 32'h0) begin errors++; $display("FAIL store_pop: wr=%b IR=%h result=%h expected 0/0020a023/0", wr, write_IR, result); end
        step();
        exp_ret += 2;
        checks++; if (wr !== 1'b0 || write_IR !== 32'h00000013) begin errors++; $display("FAIL addi_x0: wr=%b IR=%h expected 0/00000013", wr, write_IR); end
        checks++; if (retired !== exp_ret) begin errors++; $display("FAIL nowrite_retired: got %0d expected %0d", retired, exp_ret); end
    endtask

    task automatic test_jal();
        drive(32'h008000EF, 32'hDEAD, 32'hBEEF, 32'h104);
        step();
        in_valid = 1'b0;
        step();
        exp_ret++;
        checks++; if (wr !== 1'b1 || result !== 32'h104 || byp_rd !== 5'd1) begin errors++; $display("FAIL jal: wr=%b result=%h rd=%0d expected 1/00000104/1", wr, result, byp_rd); end
    endtask

    task automatic test_back_to_back();
        drive(32'h002082B3, 32'hA1, 32'h0, 32'h0);
        step();
        drive(32'h002082B3, 32'hA2, 32'h0, 32'h0);
        step();
        checks++; if (wr !== 1'b1 || result !== 32'hA1) begin errors++; $display("FAIL b2b_0: wr=%b result=%h expected 1/000000a1", wr, result); end
        drive(32'h002082B3, 32'hA3, 32'h0, 32'h0);
        step();
        in_valid = 1'b0;
        checks++; if (wr !== 1'b1 || result !== 32'hA2) begin errors++; $display("FAIL b2b_1: wr=%b result=%h expected 1/000000a2", wr, result); end
        step();
        exp_ret += 3;
        checks++; if (wr !== 1'b1 || result !== 32'hA3 || retired !== exp_ret) begin errors++; $display("FAIL b2b_2: wr=%b result=%h retired=%0d expected 1/000000a3/%0d", wr, result, retired, exp_ret); end
        step();
    endtask

    task automatic test_mid_reset();
        wb_stall = 1'b1;
        drive(32'h002082B3, 32'h55, 32'h0, 32'h0);
        step();
        drive(32'h002082B3, 32'h66, 32'h0, 32'h0);
        step();
        in_valid = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        wb_stall = 1'b0;
        checks++; if (wr !== 1'b0 || in_ready !== 1'b1 || retired !== 32'h0) begin errors++; $display("FAIL midrst: wr=%b in_ready=%b retired=%0d expected 0/1/0", wr, in_ready, retired); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (wr !== 1'b0 || retired !== 32'h0) begin errors++; $display("FAIL midrst_after_%0d: wr=%b retired=%0d expected 0/0", i, wr, retired); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_loads();
        test_stall();
        test_nowrite();
        test_jal();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
